// File: rtl/mib_burst_master_pkg.sv
// Shared types and beat-count helpers for the MIB burst master.
package mib_burst_master_pkg;

  localparam int MIB_D_BITS_DEF = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_TURN,
    ST_WAIT_ACK,
    ST_RDATA,
    ST_RTURN,
    ST_NEXT,
    ST_DONE
  } mib_mst_state_t;

  function automatic int addr_beats(input int addr_bits, input int d_bits);
    return (addr_bits + d_bits - 1) / d_bits;
  endfunction

  function automatic int data_beats(input int data_bits, input int d_bits);
    return data_bits / d_bits;
  endfunction

endpackage

// File: rtl/mib_burst_master_if.sv
// MIB bus pins between the burst master and the slave side; the tristate buffer lives above this.
interface mib_burst_master_if #(
  parameter int MIB_D_BITS = 16
);
  logic                  o_mib_start;
  logic                  o_mib_rd_wr_n;
  logic [MIB_D_BITS-1:0] o_mib_d;
  logic                  o_mib_d_oe;
  logic [MIB_D_BITS-1:0] i_mib_d;
  logic                  i_mib_slave_ack;

  modport master (
    output o_mib_start, o_mib_rd_wr_n, o_mib_d, o_mib_d_oe,
    input  i_mib_d, i_mib_slave_ack
  );

  modport slave (
    input  o_mib_start, o_mib_rd_wr_n, o_mib_d, o_mib_d_oe,
    output i_mib_d, i_mib_slave_ack
  );
endinterface

// File: rtl/mib_ack_watchdog.sv
// Counts clocks while enabled; o_expire is high on the TIMEOUT_CLKS-th enabled clock.
module mib_ack_watchdog #(
  parameter int TIMEOUT_CLKS = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);
  localparam int CNT_BITS = $clog2(TIMEOUT_CLKS + 1);

  logic [CNT_BITS-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != CNT_BITS'(TIMEOUT_CLKS))) begin
      r_cnt <= r_cnt + CNT_BITS'(1);
    end
  end

  assign o_expire = i_enable && (r_cnt == CNT_BITS'(TIMEOUT_CLKS - 1));
endmodule

// File: rtl/mib_burst_master.sv
// Bridges cscfg commands onto the MIB bus: address beats MS-first, data beats LS-first,
// auto-incrementing bursts with a per-word ack watchdog that aborts the remaining burst.
module mib_burst_master
  import mib_burst_master_pkg::*;
#(
  parameter int ADDR_BITS        = 24,
  parameter int DATA_BITS        = 32,
  parameter int MIB_D_BITS       = MIB_D_BITS_DEF,
  parameter int LEN_BITS         = 8,
  parameter int ACK_TIMEOUT_CLKS = 64,
  parameter logic [DATA_BITS-1:0] TIMEOUT_RDATA = DATA_BITS'(32'hDEAD_DEAD)
) (
  input  logic                 i_sysclk,
  input  logic                 i_arst,
  input  logic                 i_cmd_sel,
  input  logic                 i_cmd_rd_wr_n,
  input  logic [ADDR_BITS-1:0] i_cmd_addr,
  input  logic [LEN_BITS-1:0]  i_cmd_len,
  input  logic [DATA_BITS-1:0] i_cmd_wdata,
  output logic                 o_cmd_wdata_pop,
  output logic [DATA_BITS-1:0] o_cmd_rdata,
  output logic                 o_cmd_rdata_vld,
  output logic                 o_cmd_done,
  output logic                 o_cmd_timeout,
  output logic                 o_busy,
  mib_burst_master_if.master   mib
);
  localparam int AB     = addr_beats(ADDR_BITS, MIB_D_BITS);
  localparam int DB     = data_beats(DATA_BITS, MIB_D_BITS);
  localparam int AW_PAD = AB * MIB_D_BITS;
  localparam int MAXB   = (AB > DB) ? AB : DB;
  localparam int BEAT_W = $clog2(MAXB + 1);

  mib_mst_state_t          r_state, w_next_state;
  logic                    r_rd_wr_n;
  logic [ADDR_BITS-1:0]    r_addr;
  logic [LEN_BITS-1:0]     r_words_left;
  logic [BEAT_W-1:0]       r_beat;
  logic [DATA_BITS-1:0]    r_rdata;
  logic                    r_timeout;

  logic [AW_PAD-1:0]       w_addr_pad;
  logic [MIB_D_BITS-1:0]   w_addr_beat;
  logic [MIB_D_BITS-1:0]   w_data_beat;
  logic                    w_last_addr;
  logic                    w_last_data;
  logic                    w_ack;
  logic                    w_expire;
  logic                    w_more;

  assign w_addr_pad  = AW_PAD'(r_addr);
  assign w_last_addr = (r_beat == BEAT_W'(AB - 1));
  assign w_last_data = (r_beat == BEAT_W'(DB - 1));
  assign w_ack       = mib.i_mib_slave_ack;
  assign w_more      = (r_words_left != '0) && !r_timeout;
  assign o_cmd_rdata = r_rdata;

  mib_ack_watchdog #(
    .TIMEOUT_CLKS (ACK_TIMEOUT_CLKS)
  ) u_watchdog (
    .i_clk    (i_sysclk),
    .i_rst    (i_arst),
    .i_clear  (r_state != ST_WAIT_ACK),
    .i_enable (r_state == ST_WAIT_ACK),
    .o_expire (w_expire)
  );

  always_comb begin
    w_addr_beat = '0;
    for (int b = 0; b < AB; b++)
      if (r_beat == BEAT_W'(b)) w_addr_beat = w_addr_pad[(AB-1-b)*MIB_D_BITS +: MIB_D_BITS];
    w_data_beat = '0;
    for (int b = 0; b < DB; b++)
      if (r_beat == BEAT_W'(b)) w_data_beat = i_cmd_wdata[b*MIB_D_BITS +: MIB_D_BITS];
  end

  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state        = r_state;
    o_busy              = (r_state != ST_IDLE);
    o_cmd_wdata_pop     = 1'b0;
    o_cmd_rdata_vld     = 1'b0;
    o_cmd_done          = 1'b0;
    o_cmd_timeout       = 1'b0;
    mib.o_mib_start     = 1'b0;
    mib.o_mib_rd_wr_n   = r_rd_wr_n;
    mib.o_mib_d         = '0;
    mib.o_mib_d_oe      = 1'b0;
    case (r_state)
      ST_IDLE: if (i_cmd_sel) w_next_state = ST_ADDR;
      ST_ADDR: begin
        mib.o_mib_d_oe  = 1'b1;
        mib.o_mib_d     = w_addr_beat;
        mib.o_mib_start = (r_beat == '0);
        if (w_last_addr) w_next_state = r_rd_wr_n ? ST_TURN : ST_WDATA;
      end
      ST_WDATA: begin
        mib.o_mib_d_oe  = 1'b1;
        mib.o_mib_d     = w_data_beat;
        o_cmd_wdata_pop = w_last_data;
        if (w_last_data) w_next_state = ST_TURN;
      end
      ST_TURN: w_next_state = ST_WAIT_ACK;
      // An ack on the expiry clock takes priority over the timeout.
      ST_WAIT_ACK: begin
        if (w_ack)         w_next_state = r_rd_wr_n ? ((DB > 1) ? ST_RDATA : ST_RTURN) : ST_NEXT;
        else if (w_expire) w_next_state = r_rd_wr_n ? ST_RTURN : ST_NEXT;
      end
      ST_RDATA: if (w_last_data) w_next_state = ST_RTURN;
      ST_RTURN: begin
        o_cmd_rdata_vld = 1'b1;
        w_next_state    = ST_NEXT;
      end
      ST_NEXT: w_next_state = w_more ? ST_ADDR : ST_DONE;
      ST_DONE: begin
        o_cmd_done    = 1'b1;
        o_cmd_timeout = r_timeout;
        w_next_state  = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      r_rd_wr_n    <= 1'b1;
      r_addr       <= '0;
      r_words_left <= '0;
      r_beat       <= '0;
      r_rdata      <= '0;
      r_timeout    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_cmd_sel) begin
          r_rd_wr_n    <= i_cmd_rd_wr_n;
          r_addr       <= i_cmd_addr;
          r_words_left <= i_cmd_len;
          r_beat       <= '0;
          r_timeout    <= 1'b0;
        end
        ST_ADDR:  r_beat <= w_last_addr ? '0 : r_beat + BEAT_W'(1);
        ST_WDATA: r_beat <= w_last_data ? '0 : r_beat + BEAT_W'(1);
        ST_WAIT_ACK: begin
          if (w_ack) begin
            if (r_rd_wr_n) r_rdata[MIB_D_BITS-1:0] <= mib.i_mib_d;
            r_beat <= BEAT_W'(1);
          end else if (w_expire) begin
            r_timeout <= 1'b1;
            if (r_rd_wr_n) r_rdata <= TIMEOUT_RDATA;
          end
        end
        ST_RDATA: begin
          for (int b = 1; b < DB; b++)
            if (r_beat == BEAT_W'(b)) r_rdata[b*MIB_D_BITS +: MIB_D_BITS] <= mib.i_mib_d;
          r_beat <= w_last_data ? '0 : r_beat + BEAT_W'(1);
        end
        ST_NEXT: begin
          r_beat <= '0;
          if (w_more) begin
            r_words_left <= r_words_left - LEN_BITS'(1);
            r_addr       <= r_addr + ADDR_BITS'(DATA_BITS / 8);
          end
        end
        ST_DONE: r_rd_wr_n <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mib_burst_master.sv
// Randomized bench: a protocol-level slave plus a per-command expectation model.
module tb_mib_burst_master;
  logic        clk;
  logic        i_arst;
  logic        i_cmd_sel;
  logic        i_cmd_rd_wr_n;
  logic [23:0] i_cmd_addr;
  logic [7:0]  i_cmd_len;
  logic [31:0] i_cmd_wdata;
  logic        o_cmd_wdata_pop;
  logic [31:0] o_cmd_rdata;
  logic        o_cmd_rdata_vld;
  logic        o_cmd_done;
  logic        o_cmd_timeout;
  logic        o_busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wq [16];
  logic [31:0] rq [16];
  int          dly[16];

  mib_burst_master_if #(.MIB_D_BITS(16)) mib_if ();

  mib_burst_master dut (
    .i_sysclk        (clk),
    .i_arst          (i_arst),
    .i_cmd_sel       (i_cmd_sel),
    .i_cmd_rd_wr_n   (i_cmd_rd_wr_n),
    .i_cmd_addr      (i_cmd_addr),
    .i_cmd_len       (i_cmd_len),
    .i_cmd_wdata     (i_cmd_wdata),
    .o_cmd_wdata_pop (o_cmd_wdata_pop),
    .o_cmd_rdata     (o_cmd_rdata),
    .o_cmd_rdata_vld (o_cmd_rdata_vld),
    .o_cmd_done      (o_cmd_done),
    .o_cmd_timeout   (o_cmd_timeout),
    .o_busy          (o_busy),
    .mib             (mib_if)
  );

  logic [6:0] ctl;
  assign ctl = {o_busy, mib_if.o_mib_d_oe, mib_if.o_mib_start, o_cmd_wdata_pop,
                o_cmd_done, o_cmd_rdata_vld, o_cmd_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pick_dly();
    int r;
    r = $urandom_range(0, 19);
    case (r)
      0:       return 0;
      1:       return 64;
      2:       return 65;
      3:       return 63;
      default: return $urandom_range(1, 5);
    endcase
  endfunction

  // dly[w]: clocks after the word's bus turnaround that the slave acks (0 = never).
  task automatic run_cmd(input bit rd, input logic [23:0] addr, input int len);
    int to_word, exp_words, word, phase, tcnt, wi, pops, vlds, starts;
    int turn_cyc, ack_cyc, cyc, exp_cyc;
    bit finished, pop_seen;
    logic [15:0] bq[$];
    logic [23:0] exp_a;
    logic [31:0] exp_rd;
    to_word = -1; word = -1; phase = 0; tcnt = 0; wi = 0; pops = 0; vlds = 0;
    starts = 0; turn_cyc = 0; ack_cyc = 0; cyc = 0; finished = 0;
    for (int w = len; w >= 0; w--)
      if (dly[w] == 0 || dly[w] > 64) to_word = w;
    exp_words = (to_word >= 0) ? to_word + 1 : len + 1;

    @(negedge clk);
    i_cmd_sel = 1'b1; i_cmd_rd_wr_n = rd; i_cmd_addr = addr;
    i_cmd_len = 8'(len); i_cmd_wdata = wq[0];
    @(negedge clk);
    i_cmd_sel = 1'b0; i_cmd_addr = 24'($urandom); i_cmd_len = 8'($urandom);
    i_cmd_rd_wr_n = 1'($urandom);
    check_eq("busy_latency", o_busy, 1);
    check_eq("start_latency", mib_if.o_mib_start, 1);

    while (!finished && cyc < 3000) begin
      pop_seen = o_cmd_wdata_pop;
      if (pop_seen) pops++;
      check_eq("busy", o_busy, 1);
      if (o_cmd_rdata_vld) begin
        exp_rd  = (word == to_word) ? 32'hDEAD_DEAD : rq[word];
        exp_cyc = (word == to_word) ? turn_cyc + 65 : ack_cyc + 2;
        check_eq("rdata", o_cmd_rdata, exp_rd);
        check_eq("rdata_vld_cyc", cyc, exp_cyc);
        vlds++;
      end
      check_eq("timeout_without_done", o_cmd_timeout & ~o_cmd_done, 0);
      if (o_cmd_done) begin
        check_eq("timeout_flag", o_cmd_timeout, (to_word >= 0) ? 1 : 0);
        if (to_word >= 0) exp_cyc = turn_cyc + (rd ? 67 : 66);
        else              exp_cyc = ack_cyc + (rd ? 4 : 2);
        check_eq("done_cyc", cyc, exp_cyc);
        finished = 1;
      end

      mib_if.i_mib_slave_ack = 1'b0;
      mib_if.i_mib_d = 16'($urandom);
      case (phase)
        0: if (mib_if.o_mib_d_oe) begin
          word++;
          starts += int'(mib_if.o_mib_start);
          check_eq("start_first_beat", mib_if.o_mib_start, 1);
          check_eq("rd_wr_n", mib_if.o_mib_rd_wr_n, rd);
          bq = {};
          bq.push_back(mib_if.o_mib_d);
          phase = 1;
        end
        1: if (mib_if.o_mib_d_oe) begin
          check_eq("start_only_first", mib_if.o_mib_start, 0);
          bq.push_back(mib_if.o_mib_d);
        end else begin
          exp_a = addr + 24'(4 * word);
          check_eq("beat_count", bq.size(), rd ? 2 : 4);
          if (bq.size() >= 2) check_eq("addr", {bq[0], bq[1]}, {8'h00, exp_a});
          if (!rd && bq.size() >= 4) check_eq("wdata", {bq[3], bq[2]}, wq[word]);
          turn_cyc = cyc; tcnt = 0; phase = 2;
        end
        2: begin
          tcnt++;
          check_eq("oe_released", mib_if.o_mib_d_oe, 0);
          if (dly[word] != 0 && tcnt == dly[word]) begin
            mib_if.i_mib_slave_ack = 1'b1;
            ack_cyc = cyc;
            if (rd) begin
              mib_if.i_mib_d = rq[word][15:0];
              phase = 3;
            end else begin
              phase = 0;
            end
          end
        end
        default: begin
          check_eq("oe_released", mib_if.o_mib_d_oe, 0);
          mib_if.i_mib_d = rq[word][31:16];
          phase = 0;
        end
      endcase

      @(posedge clk);
      #1;
      if (pop_seen) begin
        wi++;
        i_cmd_wdata = wq[wi];
      end
      @(negedge clk);
      cyc++;
    end

    mib_if.i_mib_slave_ack = 1'b0;
    check_eq("done_seen", finished, 1);
    check_eq("pop_count", pops, rd ? 0 : exp_words);
    check_eq("vld_count", vlds, rd ? exp_words : 0);
    check_eq("start_count", starts, exp_words);
    for (int k = 0; k < 3; k++) begin
      check_eq("idle_after_done", ctl, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    i_arst = 1'b1; i_cmd_sel = 1'b0; i_cmd_rd_wr_n = 1'b0; i_cmd_addr = '0;
    i_cmd_len = '0; i_cmd_wdata = '0;
    mib_if.i_mib_d = '0; mib_if.i_mib_slave_ack = 1'b0;
    #3;
    check_eq("reset_ctl", ctl, 0);
    check_eq("reset_rd_wr_n", mib_if.o_mib_rd_wr_n, 1);
    check_eq("reset_rdata", o_cmd_rdata, 0);
    check_eq("reset_mib_d", mib_if.o_mib_d, 0);
    repeat (2) @(negedge clk);
    i_arst = 1'b0;

    // Acks while idle must not disturb anything.
    for (int k = 0; k < 4; k++) begin
      mib_if.i_mib_slave_ack = 1'b1;
      mib_if.i_mib_d = 16'($urandom);
      @(negedge clk);
      check_eq("idle_spurious_ack", ctl, 0);
    end
    mib_if.i_mib_slave_ack = 1'b0;

    wq[0] = 32'hDEAD_BEEF; dly[0] = 3;
    run_cmd(1'b0, 24'h000010, 0);

    rq[0] = 32'hBABE_CAFE; dly[0] = 2;
    run_cmd(1'b1, 24'h000014, 0);

    for (int w = 0; w < 4; w++) begin wq[w] = $urandom; dly[w] = w + 1; end
    run_cmd(1'b0, 24'h0FFFF8, 3);

    for (int w = 0; w < 3; w++) rq[w] = $urandom;
    dly[0] = 2; dly[1] = 0; dly[2] = 1;
    run_cmd(1'b1, 24'h000100, 2);

    rq[0] = $urandom; dly[0] = 64;
    run_cmd(1'b1, 24'h000200, 0);
    wq[0] = $urandom; dly[0] = 64;
    run_cmd(1'b0, 24'h000204, 0);

    for (int w = 0; w < 3; w++) begin wq[w] = $urandom; dly[w] = 2; end
    run_cmd(1'b0, 24'hFFFFF8, 2);

    // Reset asserted mid-WDATA of a write.
    @(negedge clk);
    i_cmd_sel = 1'b1; i_cmd_rd_wr_n = 1'b0; i_cmd_addr = 24'h000300; i_cmd_len = 8'd0;
    i_cmd_wdata = 32'h1234_5678;
    @(negedge clk);
    i_cmd_sel = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("pre_reset_oe", mib_if.o_mib_d_oe, 1);
    #2 i_arst = 1'b1;
    #1;
    check_eq("midburst_reset_ctl", ctl, 0);
    check_eq("midburst_reset_rd_wr_n", mib_if.o_mib_rd_wr_n, 1);
    check_eq("midburst_reset_mib_d", mib_if.o_mib_d, 0);
    check_eq("midburst_reset_rdata", o_cmd_rdata, 0);
    @(negedge clk);
    i_arst = 1'b0;
    wq[0] = $urandom; rq[0] = $urandom; dly[0] = 3;
    run_cmd(1'b0, 24'h000400, 0);
    run_cmd(1'b1, 24'h000404, 0);

    for (int t = 0; t < 25; t++) begin
      int len;
      len = $urandom_range(0, 5);
      for (int w = 0; w < 16; w++) begin
        wq[w] = $urandom; rq[w] = $urandom; dly[w] = pick_dly();
      end
      run_cmd(1'($urandom), 24'($urandom), len);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
